// File: rtl/dsp_mac_pkg.sv
// Shared types and default widths for the DSP multiply-accumulate engine.
// Used by dsp_mac_pipe and dsp_mac_engine.
package dsp_mac_pkg;

   localparam int REG_WORD_LEN  = 16;
   localparam int SRAM_ADDR_LEN = 10;
   localparam int ACC_LEN       = 40;
   localparam int TAP_LEN       = 8;
   localparam int SHIFT_W       = 6;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed multiplier, valid shift pipe and accumulator.
// Operands are taken MEM_LAT cycles after the matching issue cycle.
module dsp_mac_pipe
   import dsp_mac_pkg::*;
#(
   parameter int DATA_W     = REG_WORD_LEN,
   parameter int ACC_W      = ACC_LEN,
   parameter int MUL_STAGES = 2,
   parameter int MEM_LAT    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_i,
   input  logic                     issue_i,
   input  logic signed [DATA_W-1:0] a_i,
   input  logic signed [DATA_W-1:0] b_i,
   output logic signed [ACC_W-1:0]  acc_o,
   output logic                     drained_o
);

   localparam int D  = MEM_LAT + MUL_STAGES + 1;
   localparam int PW = 2 * DATA_W;

   logic [D-1:0]           vld_q;
   logic signed [PW-1:0]   prod_q [MUL_STAGES];
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] prod_ext;

   assign prod_ext = prod_q[MUL_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         acc_q <= '0;
         for (int i = 0; i < MUL_STAGES; i++)
            prod_q[i] <= '0;
      end else begin
         vld_q <= {vld_q[D-2:0], issue_i};
         if (vld_q[MEM_LAT-1])
            prod_q[0] <= PW'(a_i) * PW'(b_i);
         for (int i = 1; i < MUL_STAGES; i++)
            prod_q[i] <= prod_q[i-1];
         if (clr_i)
            acc_q <= '0;
         else if (vld_q[D-2])
            acc_q <= acc_q + prod_ext;
      end
   end

   // Last product has landed in the accumulator this cycle.
   assign drained_o = vld_q[D-1] & ~|vld_q[D-2:0];
   assign acc_o     = acc_q;

endmodule

// File: rtl/dsp_mac_engine.sv
// FIR multiply-accumulate engine: FSM, address generation, output scaling.
// Define DSP_MAC_SAT_EN to saturate the narrowed result and flag overflow.
module dsp_mac_engine
   import dsp_mac_pkg::*;
#(
   parameter int DATA_W     = REG_WORD_LEN,
   parameter int ADDR_W     = SRAM_ADDR_LEN,
   parameter int ACC_W      = ACC_LEN,
   parameter int TAP_W      = TAP_LEN,
   parameter int MUL_STAGES = 2,
   parameter int MEM_LAT    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  coef_base,
   input  logic [ADDR_W-1:0]  samp_base,
   input  logic [ADDR_W-1:0]  out_addr,
   input  logic [TAP_W-1:0]   ntaps,
   input  logic [SHIFT_W-1:0] shift,
   output logic               busy,
   output logic               done,
   output logic               overflow,
   output logic [ADDR_W-1:0]  read_addr_1,
   input  logic [DATA_W-1:0]  read_data_1,
   output logic [ADDR_W-1:0]  read_addr_2,
   input  logic [DATA_W-1:0]  read_data_2,
   output logic [ADDR_W-1:0]  write_addr_2,
   output logic [DATA_W-1:0]  write_data_2,
   output logic               write_en_2
);

   state_t state_q, state_d;

   logic [TAP_W-1:0]   k_q, ntaps_q;
   logic [ADDR_W-1:0]  addr1_q, addr2_q, oaddr_q;
   logic [SHIFT_W-1:0] shift_q;
   logic               clr, issue, last;
   logic               drained;
   logic signed [ACC_W-1:0] acc;
   logic [DATA_W-1:0]  result;

   assign last = (k_q == ntaps_q - TAP_W'(1));

   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      issue   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               clr     = 1'b1;
               state_d = (ntaps == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            issue = 1'b1;
            if (last)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (drained)
               state_d = WRITE;
         end
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         ntaps_q <= '0;
         addr1_q <= '0;
         addr2_q <= '0;
         oaddr_q <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            k_q     <= '0;
            ntaps_q <= ntaps;
            oaddr_q <= out_addr;
            shift_q <= shift;
            // Zero-tap jobs never issue, so the read ports keep their value.
            if (ntaps != '0) begin
               addr1_q <= coef_base;
               addr2_q <= samp_base;
            end
         end else if (state_q == ISSUE && !last) begin
            k_q     <= k_q + TAP_W'(1);
            addr1_q <= addr1_q + ADDR_W'(1);
            addr2_q <= addr2_q + ADDR_W'(1);
         end
      end
   end

   dsp_mac_pipe #(
      .DATA_W     (DATA_W),
      .ACC_W      (ACC_W),
      .MUL_STAGES (MUL_STAGES),
      .MEM_LAT    (MEM_LAT)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr),
      .issue_i   (issue),
      .a_i       (read_data_1),
      .b_i       (read_data_2),
      .acc_o     (acc),
      .drained_o (drained)
   );

`ifdef DSP_MAC_SAT_EN
   logic signed [ACC_W-1:0] scaled;
   logic [ACC_W-DATA_W:0]   hi;
   logic                    clip;
   logic                    ovf_q;

   assign scaled = acc >>> shift_q;
   assign hi     = scaled[ACC_W-1:DATA_W-1];
   assign clip   = ~(&hi | ~|hi);
   assign result = clip ? {scaled[ACC_W-1], {(DATA_W-1){~scaled[ACC_W-1]}}}
                        : scaled[DATA_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (state_q == IDLE && start)
         ovf_q <= 1'b0;
      else if (state_q == WRITE)
         ovf_q <= clip;
   end

   assign overflow = ovf_q;
`else
   assign result   = DATA_W'(acc >>> shift_q);
   assign overflow = 1'b0;
`endif

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign write_en_2   = (state_q == WRITE);
   assign write_addr_2 = write_en_2 ? oaddr_q : '0;
   assign write_data_2 = write_en_2 ? result : '0;
   assign read_addr_1  = addr1_q;
   assign read_addr_2  = addr2_q;

endmodule
